// File: rtl/counter8_pkg.sv
// Shared constants for the counter8_step slice.
package counter8_pkg;

  localparam int          CNT_W    = 8;
  localparam logic        DIR_UP   = 1'b1;
  localparam logic        DIR_DN   = 1'b0;
  localparam logic [7:0]  CNT_ZERO = 8'h00;

endpackage : counter8_pkg

// File: rtl/counter8_step_cla8.sv
// 8-bit carry-lookahead adder: two 4-bit groups.
// The group generate/propagate of the low nibble feeds the high nibble's
// carry-in directly, so the high nibble does not wait on a ripple
// through the low nibble.
module cla8
  import counter8_pkg::*;
(
  input  logic [CNT_W-1:0] a,
  input  logic [CNT_W-1:0] b,
  input  logic             ci,
  output logic [CNT_W-1:0] s,
  output logic             co
);

  logic [CNT_W-1:0] g, p;
  logic [CNT_W:0]   c;
  logic             grp_g0, grp_p0;

  assign g = a & b;
  assign p = a ^ b;

  // Low-nibble group terms; these give the carry into bit 4.
  assign grp_p0 = &p[3:0];
  assign grp_g0 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                  (p[3] & p[2] & p[1] & g[0]);

  // Carry chain inside each nibble; the nibble boundary uses the group terms.
  always_comb begin
    c = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) c[i+1] = g[i] | (p[i] & c[i]);
    c[4] = grp_g0 | (grp_p0 & ci);
    for (int i = 4; i < CNT_W; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s  = p ^ c[CNT_W-1:0];
  assign co = c[CNT_W];

endmodule : cla8

// File: rtl/counter8_step.sv
// Registered 8-bit up/down counter with programmable step and a runtime
// inclusive wrap limit. The adder result from cla8 becomes the next count.
module counter8_step
  import counter8_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = CNT_ZERO
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic [CNT_W-1:0] step,
  input  logic [CNT_W-1:0] limit,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             tc,
  output logic             ovf
);

  logic [CNT_W-1:0] add_b, add_s, cnt_nxt;
  logic             add_ci, add_co, wrap_evt;

  // Subtract as cnt + ~step + 1, so a clear carry-out means borrow.
  assign add_b  = (up == DIR_UP) ? step : ~step;
  assign add_ci = (up == DIR_DN);

  cla8 u_cla8 (
    .a  (cnt),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  assign tc = (up == DIR_UP) ? (cnt == limit) : (cnt == CNT_ZERO);

  // Next-count select: load beats en. Overruns land at 0 going up and at
  // limit going down, and the remainder is dropped. A zero step is a plain
  // hold, even when a loaded count sits above limit.
  always_comb begin
    cnt_nxt  = cnt;
    wrap_evt = 1'b0;
    if (load) begin
      cnt_nxt = load_val;
    end else if (en && (step != CNT_ZERO)) begin
      if (up == DIR_UP) begin
        if (add_co || (add_s > limit)) begin
          cnt_nxt  = CNT_ZERO;
          wrap_evt = 1'b1;
        end else begin
          cnt_nxt = add_s;
        end
      end else begin
        if (!add_co) begin
          cnt_nxt  = limit;
          wrap_evt = 1'b1;
        end else begin
          cnt_nxt = add_s;
        end
      end
    end
  end

  // Count and flag registers. A wrap in the same cycle as clr_ovf still
  // leaves the sticky flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= RESET_VAL;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      wrap <= wrap_evt;
      ovf  <= wrap_evt | (ovf & ~clr_ovf);
    end
  end

endmodule : counter8_step
